// File: rtl/timer_regs.sv
// rtl/timer_regs.sv - APB3 register block for the 8-bit timer (TDR/TCR/TSR, reconf strobe, flags, irq)
module timer_regs (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] cnt,
    output logic [7:0] tdr,
    output logic       en,
    output logic       load,
    output logic       updown,
    output logic [1:0] cks,
    output logic       tcr_reconf,
    output logic       irq
);

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;
    localparam logic [7:0] TCR_MASK = 8'hB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic       tcr_reconf_q, tcr_reconf_d;
    logic       reconf_dly_q, reconf_dly_d;
    logic [7:0] cnt_dly_q, cnt_dly_d;

    logic ack;
    logic wr_commit;
    logic ovf_set;
    logic udf_set;
    logic mapped;

    assign ack       = (state_q == ST_ACK);
    assign wr_commit = ack & pwrite;
    assign mapped    = (paddr == ADDR_TDR) | (paddr == ADDR_TCR) | (paddr == ADDR_TSR);

    // A wrap seen right after a reconfiguration is the counter jumping, not counting.
    assign ovf_set = (cnt_dly_q == 8'hFF) & (cnt == 8'h00) & ~tcr_q[5] & tcr_q[4] & ~reconf_dly_q;
    assign udf_set = (cnt_dly_q == 8'h00) & (cnt == 8'hFF) &  tcr_q[5] & tcr_q[4] & ~reconf_dly_q;

    always_comb begin
        state_d      = state_q;
        tdr_d        = tdr_q;
        tcr_d        = tcr_q;
        tcr_reconf_d = 1'b0;
        reconf_dly_d = tcr_reconf_q;
        cnt_dly_d    = cnt;
        case (state_q)
            ST_IDLE: if (psel && !penable) state_d = ST_WAIT;
            ST_WAIT: state_d = (psel && penable) ? ST_ACK : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (wr_commit && paddr == ADDR_TDR) tdr_d = pwdata;
        if (wr_commit && paddr == ADDR_TCR) begin
            tcr_d        = pwdata & TCR_MASK;
            tcr_reconf_d = 1'b1;
        end
        // Set beats a simultaneous write-one-to-clear.
        ovf_d = ovf_set | (ovf_q & ~(wr_commit && paddr == ADDR_TSR && pwdata[0]));
        udf_d = udf_set | (udf_q & ~(wr_commit && paddr == ADDR_TSR && pwdata[1]));
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            tdr_q        <= 8'h00;
            tcr_q        <= 8'h00;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            tcr_reconf_q <= 1'b0;
            reconf_dly_q <= 1'b1;
            cnt_dly_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            tdr_q        <= tdr_d;
            tcr_q        <= tcr_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            tcr_reconf_q <= tcr_reconf_d;
            reconf_dly_q <= reconf_dly_d;
            cnt_dly_q    <= cnt_dly_d;
        end
    end

    always_comb begin
        prdata = 8'h00;
        if (ack) begin
            case (paddr)
                ADDR_TDR: prdata = tdr_q;
                ADDR_TCR: prdata = tcr_q;
                ADDR_TSR: prdata = {6'b0, udf_q, ovf_q};
                default:  prdata = 8'h00;
            endcase
        end
    end

    assign pready     = ack;
    assign pslverr    = ack & ~mapped;
    assign tdr        = tdr_q;
    assign en         = tcr_q[4];
    assign load       = tcr_q[7];
    assign updown     = tcr_q[5];
    assign cks        = tcr_q[1:0];
    assign tcr_reconf = tcr_reconf_q;
    assign irq        = tcr_q[2] & (ovf_q | udf_q);

endmodule

// File: tb/tb_timer_regs.sv
// tb/tb_timer_regs.sv - directed self-checking bench for timer_regs
module tb_timer_regs;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata, cnt, tdr;
    logic       pready, pslverr, en, load, updown, tcr_reconf, irq;
    logic [1:0] cks;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pc0;
    int ready_seen;
    logic [7:0] rd;
    logic       err;

    timer_regs dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .cnt(cnt), .tdr(tdr), .en(en),
        .load(load), .updown(updown), .cks(cks), .tcr_reconf(tcr_reconf), .irq(irq)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (tcr_reconf) pulse_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // SETUP, WAIT, ACK; optionally drive cnt during the ACK cycle.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic ack_cnt_en, input logic [7:0] ack_cnt,
                       output logic [7:0] rdata, output logic rerr);
        int n;
        step(1);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        step(1);
        penable = 1'b1;
        n = 1;
        while (!pready && n < 8) begin
            step(1);
            n++;
        end
        chk("latency", n, 2);
        if (ack_cnt_en) cnt = ack_cnt;
        rdata = prdata;
        rerr  = pslverr;
        step(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic       e;
        apb(1'b1, a, d, 1'b0, 8'h00, r, e);
        chk("wr_err", e, 0);
    endtask

    task automatic rd_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        logic       e;
        apb(1'b0, a, 8'h00, 1'b0, 8'h00, r, e);
        chk(tag, r, exp);
        chk("rd_err", e, 0);
    endtask

    initial begin
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; cnt = 8'h00;
        step(3);
        chk("rst_pready", pready, 0);
        chk("rst_prdata", prdata, 8'h00);
        chk("rst_reconf", tcr_reconf, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tdr", tdr, 8'h00);
        chk("rst_ctrl", {load, updown, en, cks}, 5'b0);
        preset_n = 1'b1;
        step(1);

        rd_reg("rd_tdr0", 8'h00, 8'h00);
        rd_reg("rd_tcr0", 8'h01, 8'h00);
        rd_reg("rd_tsr0", 8'h02, 8'h00);

        pc0 = pulse_cnt;
        wr_reg(8'h00, 8'hA5);
        step(2);
        chk("tdr_no_pulse", pulse_cnt, pc0);
        wr_reg(8'h01, 8'hFF);
        chk("reconf_hi", tcr_reconf, 1);
        step(1);
        chk("reconf_lo", tcr_reconf, 0);
        chk("reconf_count", pulse_cnt, pc0 + 1);
        rd_reg("rd_tdr_a5", 8'h00, 8'hA5);
        rd_reg("rd_tcr_b7", 8'h01, 8'hB7);
        chk("ctrl_ff", {load, updown, en, cks}, 5'b11111);
        chk("tdr_out", tdr, 8'hA5);

        // Overflow counting up
        wr_reg(8'h01, 8'h14);
        step(2);
        cnt = 8'hFE; step(2);
        cnt = 8'hFF; step(1);
        cnt = 8'h00; step(1);
        chk("irq_ovf", irq, 1);
        rd_reg("tsr_ovf", 8'h02, 8'h01);
        wr_reg(8'h02, 8'h01);
        rd_reg("tsr_clr", 8'h02, 8'h00);
        chk("irq_clr", irq, 0);

        // Underflow counting down
        wr_reg(8'h01, 8'h30);
        step(2);
        cnt = 8'hFF; step(1);
        rd_reg("tsr_udf", 8'h02, 8'h02);
        chk("irq_no_ie", irq, 0);
        wr_reg(8'h02, 8'h02);
        cnt = 8'h00; step(2);
        wr_reg(8'h01, 8'h30);
        step(1);
        cnt = 8'hFF; step(2);
        rd_reg("tsr_masked", 8'h02, 8'h00);

        // Overflow coinciding with W1C of ovf
        wr_reg(8'h01, 8'h14);
        step(2);
        apb(1'b1, 8'h02, 8'h01, 1'b1, 8'h00, rd, err);
        step(1);
        rd_reg("tsr_setwins", 8'h02, 8'h01);
        chk("irq_setwins", irq, 1);

        // Unmapped address
        pc0 = pulse_cnt;
        apb(1'b1, 8'h07, 8'h3C, 1'b0, 8'h00, rd, err);
        chk("unmap_err", err, 1);
        chk("unmap_rd", rd, 8'h00);
        rd_reg("unmap_tdr", 8'h00, 8'hA5);
        rd_reg("unmap_tcr", 8'h01, 8'h14);
        rd_reg("unmap_tsr", 8'h02, 8'h01);
        chk("unmap_pulse", pulse_cnt, pc0);

        // Abort: psel drops during WAIT
        ready_seen = 0;
        step(1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h00;
        step(1);
        psel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pready) ready_seen++;
            step(1);
        end
        chk("abort_ready", ready_seen, 0);
        chk("abort_pulse", pulse_cnt, pc0);
        chk("abort_en", en, 1);
        rd_reg("abort_tcr", 8'h01, 8'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
